// File: rtl/response_capture.sv
// Triggered response capture: samples {s2,s1} for NSAMP cycles into a FIFO drained by a ready/valid port.
// Optional macro RESPONSE_CAPTURE_DROP_CNT_EN adds an 8-bit saturating dropped-sample counter (drop_cnt).
module response_capture #(
   parameter int W     = 3,
   parameter int DEPTH = 8,
   parameter int NSAMP = 4
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           arm,
   input  logic           trig,
   input  logic [W-1:0]   s1,
   input  logic [W-1:0]   s2,
   output logic           rd_valid,
   input  logic           rd_ready,
   output logic [2*W-1:0] rd_data,
   output logic           busy,
   output logic           done,
   output logic           overflow
`ifdef RESPONSE_CAPTURE_DROP_CNT_EN
   ,
   output logic [7:0]     drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(NSAMP + 1);
   localparam logic [CW-1:0] LAST = CW'(NSAMP - 1);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [CW-1:0]    r_count;
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [2*W-1:0]   r_mem [DEPTH];
   logic [2*W-1:0]   r_rdData;
   logic             r_overflow;

   logic             w_sample;
   logic             w_lastSample;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_rearm;
   logic             w_nextNonEmpty;
   logic [AW:0]      w_rptrNext;
   logic [2*W-1:0]   w_word;

   assign w_word       = {s2, s1};
   assign w_sample     = ((r_state == ARMED) && trig) || (r_state == CAPTURE);
   assign w_lastSample = w_sample && (r_count == LAST);
   assign w_empty      = (r_wptr == r_rptr);
   assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop        = !w_empty && rd_ready;
   assign w_push       = w_sample && (!w_full || w_pop);
   assign w_drop       = w_sample && w_full && !w_pop;
   assign w_rearm      = arm && (r_state == DONE);
   assign w_rptrNext   = r_rptr + {{AW{1'b0}}, w_pop};
   assign w_nextNonEmpty = w_push || (w_rptrNext != r_wptr);

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (arm) w_stateNext = ARMED;
         ARMED:   if (trig) w_stateNext = w_lastSample ? DONE : CAPTURE;
         CAPTURE: if (w_lastSample) w_stateNext = DONE;
         DONE:    if (arm) w_stateNext = ARMED;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_stateNext;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (w_sample) begin
         r_count <= w_lastSample ? '0 : r_count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= w_word;
   end

   // The head register bypasses the incoming word when it lands in the slot that becomes the head.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_rdData   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         r_rptr <= w_rptrNext;
         if (w_nextNonEmpty)
            r_rdData <= (w_push && (w_rptrNext == r_wptr)) ? w_word : r_mem[w_rptrNext[AW-1:0]];
         if (w_rearm)     r_overflow <= 1'b0;
         else if (w_drop) r_overflow <= 1'b1;
      end
   end

`ifdef RESPONSE_CAPTURE_DROP_CNT_EN
   logic [7:0] r_dropCnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                 r_dropCnt <= 8'd0;
      else if (w_rearm)                          r_dropCnt <= 8'd0;
      else if (w_drop && (r_dropCnt != 8'hFF))   r_dropCnt <= r_dropCnt + 8'd1;
   end

   assign drop_cnt = r_dropCnt;
`endif

   assign rd_valid = !w_empty;
   assign rd_data  = r_rdData;
   assign busy     = (r_state == ARMED) || (r_state == CAPTURE);
   assign done     = (r_state == DONE);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_response_capture.sv
// Directed bench: instance A has DEPTH=8, instance B has DEPTH=2; both NSAMP=4, W=3, shared stimulus.
module tb_response_capture;

   logic       clk = 1'b0;
   logic       rstn, arm, trig, rdyA, rdyB;
   logic [5:0] sv;
   logic       validA, busyA, doneA, ovA;
   logic       validB, busyB, doneB, ovB;
   logic [5:0] dataA, dataB;
`ifdef RESPONSE_CAPTURE_DROP_CNT_EN
   logic [7:0] dropA, dropB;
`endif
   int nCompared = 0;
   int nMismatch = 0;

   always #5 clk = ~clk;

   response_capture #(.W(3), .DEPTH(8), .NSAMP(4)) dutA (
      .clk(clk), .rstn(rstn), .arm(arm), .trig(trig), .s1(sv[2:0]), .s2(sv[5:3]),
      .rd_valid(validA), .rd_ready(rdyA), .rd_data(dataA),
      .busy(busyA), .done(doneA), .overflow(ovA)
`ifdef RESPONSE_CAPTURE_DROP_CNT_EN
      , .drop_cnt(dropA)
`endif
   );

   response_capture #(.W(3), .DEPTH(2), .NSAMP(4)) dutB (
      .clk(clk), .rstn(rstn), .arm(arm), .trig(trig), .s1(sv[2:0]), .s2(sv[5:3]),
      .rd_valid(validB), .rd_ready(rdyB), .rd_data(dataB),
      .busy(busyB), .done(doneB), .overflow(ovB)
`ifdef RESPONSE_CAPTURE_DROP_CNT_EN
      , .drop_cnt(dropB)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstn = 1'b0; arm = 1'b0; trig = 1'b0; rdyA = 1'b0; rdyB = 1'b0; sv = 6'o00;
      tick();
      rstn = 1'b1;
   endtask

   task automatic doArm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic doRun(input logic [5:0] v0, input logic [5:0] v1, input logic [5:0] v2, input logic [5:0] v3);
      trig = 1'b1; sv = v0; tick();
      trig = 1'b0; sv = v1; tick();
      sv = v2; tick();
      sv = v3; tick();
   endtask

   task automatic test_reset();
      rstn = 1'b0; arm = 1'b0; trig = 1'b0; rdyA = 1'b0; rdyB = 1'b0; sv = 6'o00;
      #1;
      nCompared++; if (validA !== 1'b0) begin nMismatch++; $display("FAIL reset_valid: got %b want 0", validA); end
      nCompared++; if (dataA !== 6'o00) begin nMismatch++; $display("FAIL reset_data: got %o want 00", dataA); end
      nCompared++; if ({busyA, doneA, ovA} !== 3'b000) begin nMismatch++; $display("FAIL reset_flags: got %b want 000", {busyA, doneA, ovA}); end
      nCompared++; if ({validB, busyB, doneB, ovB} !== 4'b0000) begin nMismatch++; $display("FAIL reset_flagsB: got %b want 0000", {validB, busyB, doneB, ovB}); end
      rstn = 1'b1;
      trig = 1'b1; sv = 6'o77; tick(); trig = 1'b0;
      tick();
      nCompared++; if ({validA, busyA, doneA} !== 3'b000) begin nMismatch++; $display("FAIL idle_trig: got %b want 000", {validA, busyA, doneA}); end
   endtask

   task automatic test_capture();
      logic [5:0] exp [3];
      exp[0] = 6'o22; exp[1] = 6'o33; exp[2] = 6'o44;
      doReset();
      doArm();
      nCompared++; if ({busyA, doneA} !== 2'b10) begin nMismatch++; $display("FAIL armed_flags: got %b want 10", {busyA, doneA}); end
      trig = 1'b1; sv = 6'o11; tick(); trig = 1'b0;
      nCompared++; if ({validA, dataA} !== {1'b1, 6'o11}) begin nMismatch++; $display("FAIL first_sample: got %b/%o want 1/11", validA, dataA); end
      sv = 6'o22; tick();
      sv = 6'o33; tick();
      sv = 6'o44; tick();
      nCompared++; if ({busyA, doneA, ovA} !== 3'b010) begin nMismatch++; $display("FAIL done_flags: got %b want 010", {busyA, doneA, ovA}); end
      nCompared++; if (dataA !== 6'o11) begin nMismatch++; $display("FAIL done_head: got %o want 11", dataA); end
      trig = 1'b1; sv = 6'o55; tick(); trig = 1'b0;
      nCompared++; if ({doneA, dataA} !== {1'b1, 6'o11}) begin nMismatch++; $display("FAIL done_trig_ignored: got %b/%o want 1/11", doneA, dataA); end
      rdyA = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nCompared++; if ({validA, dataA} !== {1'b1, exp[i]}) begin nMismatch++; $display("FAIL pop_%0d: got %b/%o want 1/%o", i, validA, dataA, exp[i]); end
      end
      rdyA = 1'b0; tick();
      nCompared++; if ({validA, dataA} !== {1'b1, 6'o44}) begin nMismatch++; $display("FAIL hold_stable: got %b/%o want 1/44", validA, dataA); end
      rdyA = 1'b1; tick(); rdyA = 1'b0;
      nCompared++; if (validA !== 1'b0) begin nMismatch++; $display("FAIL drained: got %b want 0", validA); end
   endtask

   task automatic test_overflow();
      doReset();
      doArm();
      doRun(6'o11, 6'o22, 6'o33, 6'o44);
      nCompared++; if ({doneB, ovB, validB, dataB} !== {3'b111, 6'o11}) begin nMismatch++; $display("FAIL ovf_state: got %b%b%b/%o want 111/11", doneB, ovB, validB, dataB); end
`ifdef RESPONSE_CAPTURE_DROP_CNT_EN
      nCompared++; if (dropB !== 8'd2) begin nMismatch++; $display("FAIL ovf_dropcnt: got %0d want 2", dropB); end
`endif
      rdyB = 1'b1; tick();
      nCompared++; if ({validB, dataB} !== {1'b1, 6'o22}) begin nMismatch++; $display("FAIL ovf_second: got %b/%o want 1/22", validB, dataB); end
      tick(); rdyB = 1'b0;
      nCompared++; if (validB !== 1'b0) begin nMismatch++; $display("FAIL ovf_kept_two: got %b want 0", validB); end
      doArm();
      nCompared++; if ({busyB, ovB} !== 2'b10) begin nMismatch++; $display("FAIL rearm_clear: got %b want 10", {busyB, ovB}); end
`ifdef RESPONSE_CAPTURE_DROP_CNT_EN
      nCompared++; if (dropB !== 8'd0) begin nMismatch++; $display("FAIL rearm_dropcnt: got %0d want 0", dropB); end
`endif
   endtask

   task automatic test_streaming();
      logic [5:0] vals [4];
      vals[0] = 6'o11; vals[1] = 6'o22; vals[2] = 6'o33; vals[3] = 6'o44;
      doReset();
      rdyB = 1'b1;
      doArm();
      for (int i = 0; i < 4; i++) begin
         trig = (i == 0); sv = vals[i]; tick();
         nCompared++; if ({validB, dataB} !== {1'b1, vals[i]}) begin nMismatch++; $display("FAIL stream_%0d: got %b/%o want 1/%o", i, validB, dataB, vals[i]); end
      end
      trig = 1'b0;
      tick(); rdyB = 1'b0;
      nCompared++; if ({validB, doneB, ovB} !== 3'b010) begin nMismatch++; $display("FAIL stream_end: got %b want 010", {validB, doneB, ovB}); end
   endtask

   task automatic test_full_push_pop();
      doReset();
      doArm();
      trig = 1'b1; sv = 6'o11; tick(); trig = 1'b0;
      sv = 6'o22; tick();
      nCompared++; if (dataB !== 6'o11) begin nMismatch++; $display("FAIL full_head: got %o want 11", dataB); end
      rdyB = 1'b1; sv = 6'o33; tick();
      nCompared++; if ({validB, dataB} !== {1'b1, 6'o22}) begin nMismatch++; $display("FAIL full_pushpop: got %b/%o want 1/22", validB, dataB); end
      sv = 6'o44; tick();
      nCompared++; if ({doneB, ovB, dataB} !== {2'b10, 6'o33}) begin nMismatch++; $display("FAIL full_nodrop: got %b%b/%o want 10/33", doneB, ovB, dataB); end
      tick();
      nCompared++; if ({validB, dataB} !== {1'b1, 6'o44}) begin nMismatch++; $display("FAIL full_last: got %b/%o want 1/44", validB, dataB); end
      tick(); rdyB = 1'b0;
      nCompared++; if (validB !== 1'b0) begin nMismatch++; $display("FAIL full_empty: got %b want 0", validB); end
   endtask

   task automatic test_reset_mid();
      doReset();
      doArm();
      trig = 1'b1; sv = 6'o11; tick(); trig = 1'b0;
      sv = 6'o22; tick();
      nCompared++; if ({busyA, validA} !== 2'b11) begin nMismatch++; $display("FAIL mid_capturing: got %b want 11", {busyA, validA}); end
      rstn = 1'b0; #1;
      nCompared++; if ({busyA, doneA, validA, dataA} !== {3'b000, 6'o00}) begin nMismatch++; $display("FAIL mid_async: got %b%b%b/%o want 000/00", busyA, doneA, validA, dataA); end
      tick(); rstn = 1'b1;
      trig = 1'b1; sv = 6'o55; tick(); trig = 1'b0;
      tick();
      nCompared++; if ({busyA, validA, dataA} !== {2'b00, 6'o00}) begin nMismatch++; $display("FAIL mid_after: got %b%b/%o want 00/00", busyA, validA, dataA); end
   endtask

   task automatic test_wrap();
      logic [5:0] exp [5];
      exp[0] = 6'o00; exp[1] = 6'o12; exp[2] = 6'o23; exp[3] = 6'o34; exp[4] = 6'o45;
      doReset();
      doArm();
      doRun(6'o11, 6'o22, 6'o33, 6'o44);
      rdyA = 1'b1; for (int i = 0; i < 4; i++) tick(); rdyA = 1'b0;
      doArm();
      doRun(6'o55, 6'o66, 6'o77, 6'o00);
      rdyA = 1'b1; tick(); tick(); rdyA = 1'b0;
      nCompared++; if ({validA, dataA} !== {1'b1, 6'o77}) begin nMismatch++; $display("FAIL wrap_old_head: got %b/%o want 1/77", validA, dataA); end
      doArm();
      nCompared++; if ({busyA, doneA} !== 2'b10) begin nMismatch++; $display("FAIL wrap_rearm: got %b want 10", {busyA, doneA}); end
      doRun(6'o12, 6'o23, 6'o34, 6'o45);
      nCompared++; if ({doneA, dataA} !== {1'b1, 6'o77}) begin nMismatch++; $display("FAIL wrap_head_kept: got %b/%o want 1/77", doneA, dataA); end
      rdyA = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         nCompared++; if ({validA, dataA} !== {1'b1, exp[i]}) begin nMismatch++; $display("FAIL wrap_pop_%0d: got %b/%o want 1/%o", i, validA, dataA, exp[i]); end
      end
      tick(); rdyA = 1'b0;
      nCompared++; if (validA !== 1'b0) begin nMismatch++; $display("FAIL wrap_empty: got %b want 0", validA); end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_overflow();
      test_streaming();
      test_full_push_pop();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
